// File: rtl/shift_seq_pkg.sv
// Shared encodings for the sequential shift/rotate unit: operation codes,
// FSM states and default datapath geometry.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-step combinational shifter: applies one power-of-two shift chosen by a
// one-hot Step select. An all-zero Step passes In through unchanged.
module shift_step #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Step,
  output logic [WIDTH-1:0] Out
);
  import shift_seq_pkg::*;

  logic [CNT_W-1:0][WIDTH-1:0] w_cand;
  logic signed [WIDTH-1:0]     w_sin;

  assign w_sin = In;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_W; gi++) begin : g_step
      localparam int S = 2 ** gi;
      logic [WIDTH-1:0] w_rol;
      logic [WIDTH-1:0] w_sll;
      logic [WIDTH-1:0] w_sra;
      logic [WIDTH-1:0] w_srl;

      assign w_rol = (In << S) | (In >> (WIDTH - S));
      assign w_sll = In << S;
      // Kept in its own assignment so the signed operand is not flattened to unsigned by a mux.
      assign w_sra = w_sin >>> S;
      assign w_srl = In >> S;

      assign w_cand[gi] = (Op == OP_ROL) ? w_rol :
                          (Op == OP_SLL) ? w_sll :
                          (Op == OP_SRA) ? w_sra : w_srl;
    end
  endgenerate

  always_comb begin
    Out = In;
    if (|Step) begin
      Out = '0;
      for (int i = 0; i < CNT_W; i++) begin
        if (Step[i]) Out = Out | w_cand[i];
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: consumes the remaining count one set bit per
// cycle (largest first) and reports completion with a one-cycle done pulse.
module shift_seq #(
  parameter int WIDTH = shift_seq_pkg::DEF_WIDTH,
  parameter int CNT_W = shift_seq_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Cnt,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);
  import shift_seq_pkg::*;

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_rem;

  logic [CNT_W-1:0] w_onehot;
  logic [CNT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_step_out;

  // Highest set bit of the remaining count selects this cycle's step.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (r_rem[i]) begin
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_rem_next = r_rem & ~w_onehot;

  shift_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .In  (Out),
    .Op  (r_op),
    .Step(w_onehot),
    .Out (w_step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_ROL;
      r_rem   <= '0;
      Out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            Out     <= In;
            r_op    <= op_e'(Op);
            r_rem   <= Cnt;
            r_state <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_rem != '0) begin
            Out   <= w_step_out;
            r_rem <= w_rem_next;
          end
          if (w_rem_next == '0) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            Out     <= In;
            r_op    <= op_e'(Op);
            r_rem   <= Cnt;
            r_state <= SHIFT;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
